// File: rtl/startup_pkg.sv
// startup_pkg: shared state codes, default parameters and counter width helper for the startup sequencer
package startup_pkg;
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } startup_state_t;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_CYC = 65000;
  localparam int DEF_HOLD_CYC     = 256;
  localparam int DEF_N_RST        = 3;
  localparam int DEF_STAGGER_CYC  = 16;
  function automatic int cw(input int v);
    return $clog2(v < 2 ? 2 : v);
  endfunction
endpackage

// File: rtl/startup_seq_if.sv
// startup_seq_if: clock-wizard/button inputs and reset/status outputs of the startup sequencer
interface startup_seq_if #(parameter int N_RST = 3);
  logic             locked;
  logic             btn;
  logic [N_RST-1:0] rst_out;
  logic             ready;
  logic [1:0]       state;
  modport master (output locked, btn, input rst_out, ready, state);
  modport slave  (input locked, btn, output rst_out, ready, state);
endinterface

// File: rtl/sync_debounce.sv
// sync_debounce: shift-register synchroniser with an optional stability filter on its output
module sync_debounce
  import startup_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter bit DEBOUNCE     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= {sr[SYNC_STAGES-2:0], din};
  generate
    if (DEBOUNCE) begin : g_db
      localparam int CW = cw(DEBOUNCE_CYC);
      logic [CW-1:0] cnt;
      logic          lvl;
      // the counter measures how long the synchronised input has disagreed with the accepted level
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          cnt <= '0;
          lvl <= 1'b0;
        end else if (sr[SYNC_STAGES-1] == lvl) cnt <= '0;
        else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
          lvl <= sr[SYNC_STAGES-1];
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      assign dout = lvl;
    end else begin : g_nd
      assign dout = sr[SYNC_STAGES-1];
    end
  endgenerate
endmodule

// File: rtl/startup_seq.sv
// startup_seq: waits for lock, holds all resets, then releases them one by one; restarts on lock loss or button
module startup_seq
  import startup_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int N_RST        = DEF_N_RST,
  parameter int STAGGER_CYC  = DEF_STAGGER_CYC
) (
  input logic          clk,
  input logic          rst_n,
  startup_seq_if.slave bus
);
  localparam int HW = cw(HOLD_CYC);
  localparam int GW = cw(STAGGER_CYC);
  localparam int IW = cw(N_RST);
  localparam logic [1:0] S_WAIT = 2'(WAIT_LOCK);
  localparam logic [1:0] S_HOLD = 2'(HOLD);
  localparam logic [1:0] S_REL  = 2'(RELEASE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  logic             lock_s, btn_db, abort;
  logic [1:0]       st;
  logic [HW-1:0]    hcnt;
  logic [GW-1:0]    scnt;
  logic [IW-1:0]    idx;
  logic [N_RST-1:0] rst_q;
  logic             rdy;
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(2), .DEBOUNCE(1'b0)) u_lock (
    .clk(clk), .rst_n(rst_n), .din(bus.locked), .dout(lock_s)
  );
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC), .DEBOUNCE(1'b1)) u_btn (
    .clk(clk), .rst_n(rst_n), .din(bus.btn), .dout(btn_db)
  );
  assign abort = !lock_s || btn_db;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= S_WAIT;
      hcnt  <= '0;
      scnt  <= '0;
      idx   <= '0;
      rst_q <= '1;
      rdy   <= 1'b0;
    end else if (abort) begin
      st    <= S_WAIT;
      hcnt  <= '0;
      scnt  <= '0;
      idx   <= '0;
      rst_q <= '1;
      rdy   <= 1'b0;
    end else begin
      case (st)
        S_WAIT: st <= S_HOLD;
        S_HOLD:
          if (hcnt == HW'(HOLD_CYC - 1)) begin
            st   <= S_REL;
            hcnt <= '0;
            scnt <= '0;
            idx  <= '0;
          end else hcnt <= hcnt + 1'b1;
        S_REL:
          if (scnt == GW'(STAGGER_CYC - 1)) begin
            scnt  <= '0;
            rst_q <= rst_q & ~(N_RST'(1) << idx);
            idx   <= idx + 1'b1;
            if (idx == IW'(N_RST - 1)) begin
              st  <= S_RUN;
              rdy <= 1'b1;
            end
          end else scnt <= scnt + 1'b1;
        default: ;
      endcase
    end
  assign bus.rst_out = rst_q;
  assign bus.ready   = rdy;
  assign bus.state   = st;
endmodule

// File: tb/tb_startup_seq.sv
// tb_startup_seq: vector table, corner-case sequences and random stimulus against a timing-arithmetic model
module tb_startup_seq;
  import startup_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1, locked = 1'b0, btn = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  startup_seq_if #(.N_RST(3)) a_if ();
  startup_seq_if #(.N_RST(1)) b_if ();
  assign a_if.locked = locked;
  assign a_if.btn    = btn;
  assign b_if.locked = locked;
  assign b_if.btn    = btn;
  startup_seq #(.SYNC_STAGES(2), .DEBOUNCE_CYC(64), .HOLD_CYC(256), .N_RST(3), .STAGGER_CYC(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
  );
  startup_seq #(.SYNC_STAGES(3), .DEBOUNCE_CYC(4), .HOLD_CYC(8), .N_RST(1), .STAGGER_CYC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
  );
  int S[2] = '{2, 3};
  int D[2] = '{64, 4};
  int H[2] = '{256, 8};
  int N[2] = '{3, 1};
  int G[2] = '{16, 1};
  logic [3:0] lsr[2], bsr[2];
  int         streak[2], start[2];
  logic       db[2];
  int         cyc;
  logic [2:0] e_rst[2];
  logic       e_rdy[2];
  logic [1:0] e_st[2];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      lsr[d] = '0; bsr[d] = '0; streak[d] = 0; db[d] = 1'b0; start[d] = -1;
      e_rst[d] = 3'((1 << N[d]) - 1); e_rdy[d] = 1'b0; e_st[d] = 2'd0;
    end
  endtask
  // expected outputs follow from the number of edges elapsed since the sequence (re)started
  task automatic model_step();
    int el;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!lsr[d][S[d]-1] || db[d]) start[d] = -1;
      else if (start[d] < 0) start[d] = cyc;
      if (bsr[d][S[d]-1] != db[d]) begin
        streak[d]++;
        if (streak[d] == D[d]) begin
          db[d] = bsr[d][S[d]-1];
          streak[d] = 0;
        end
      end else streak[d] = 0;
      lsr[d] = {lsr[d][2:0], locked};
      bsr[d] = {bsr[d][2:0], btn};
      if (start[d] < 0) begin
        e_rst[d] = 3'((1 << N[d]) - 1); e_rdy[d] = 1'b0; e_st[d] = 2'd0;
      end else begin
        el = cyc - start[d];
        e_st[d]  = el < H[d] ? 2'd1 : (el < H[d] + N[d] * G[d] ? 2'd2 : 2'd3);
        e_rdy[d] = el >= H[d] + N[d] * G[d];
        e_rst[d] = '0;
        for (int k = 0; k < N[d]; k++) e_rst[d][k] = el < H[d] + (k + 1) * G[d];
      end
    end
  endtask
  initial begin
    model_reset();
    cyc = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end
  initial forever begin
    @(negedge clk);
    #2;
    chk("model_a_rst", 32'(a_if.rst_out), 32'(e_rst[0]));
    chk("model_a_ready", 32'(a_if.ready), 32'(e_rdy[0]));
    chk("model_a_state", 32'(a_if.state), 32'(e_st[0]));
    chk("model_b_rst", 32'(b_if.rst_out), 32'(e_rst[1][0]));
    chk("model_b_ready", 32'(b_if.ready), 32'(e_rdy[1]));
    chk("model_b_state", 32'(b_if.state), 32'(e_st[1]));
  end
  typedef struct {
    logic       lk;
    logic       b;
    int         n;
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] st;
  } vec_t;
  vec_t tv[16];
  task automatic check_a(input string nm, input logic [2:0] r, input logic y, input logic [1:0] s);
    chk({nm, "_rst"}, 32'(a_if.rst_out), 32'(r));
    chk({nm, "_ready"}, 32'(a_if.ready), 32'(y));
    chk({nm, "_state"}, 32'(a_if.state), 32'(s));
  endtask
  initial begin
    tv[0]  = '{1'b1, 1'b0, 3,    3'b111, 1'b0, 2'd1};
    tv[1]  = '{1'b1, 1'b0, 255,  3'b111, 1'b0, 2'd1};
    tv[2]  = '{1'b1, 1'b0, 1,    3'b111, 1'b0, 2'd2};
    tv[3]  = '{1'b1, 1'b0, 15,   3'b111, 1'b0, 2'd2};
    tv[4]  = '{1'b1, 1'b0, 1,    3'b110, 1'b0, 2'd2};
    tv[5]  = '{1'b1, 1'b0, 16,   3'b100, 1'b0, 2'd2};
    tv[6]  = '{1'b1, 1'b0, 15,   3'b100, 1'b0, 2'd2};
    tv[7]  = '{1'b1, 1'b0, 1,    3'b000, 1'b1, 2'd3};
    tv[8]  = '{1'b1, 1'b0, 10,   3'b000, 1'b1, 2'd3};
    tv[9]  = '{1'b1, 1'b1, 10,   3'b000, 1'b1, 2'd3};
    tv[10] = '{1'b1, 1'b0, 80,   3'b000, 1'b1, 2'd3};
    tv[11] = '{1'b1, 1'b1, 66,   3'b000, 1'b1, 2'd3};
    tv[12] = '{1'b1, 1'b1, 1,    3'b111, 1'b0, 2'd0};
    tv[13] = '{1'b1, 1'b1, 1000, 3'b111, 1'b0, 2'd0};
    tv[14] = '{1'b1, 1'b0, 66,   3'b111, 1'b0, 2'd0};
    tv[15] = '{1'b1, 1'b0, 1,    3'b111, 1'b0, 2'd1};
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_a("reset_a", 3'b111, 1'b0, 2'd0);
    chk("reset_b_rst", 32'(b_if.rst_out), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      locked = tv[i].lk;
      btn    = tv[i].b;
      repeat (tv[i].n) @(negedge clk);
      #1 check_a($sformatf("vec%0d", i), tv[i].rst, tv[i].rdy, tv[i].st);
    end
    // lock loss while the first reset bit is already released
    repeat (275) @(negedge clk);
    #1 check_a("rel_before_drop", 3'b110, 1'b0, 2'd2);
    @(negedge clk);
    locked = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_a("drop_sync", 3'b110, 1'b0, 2'd2);
    @(negedge clk);
    #1 check_a("drop_abort", 3'b111, 1'b0, 2'd0);
    repeat (10) @(negedge clk);
    locked = 1'b1;
    repeat (12) @(negedge clk);
    #1 chk("b_ready_early", 32'(b_if.ready), 32'd0);
    chk("b_rst_early", 32'(b_if.rst_out), 32'd1);
    @(negedge clk);
    #1 chk("b_ready_on_time", 32'(b_if.ready), 32'd1);
    chk("b_rst_on_time", 32'(b_if.rst_out), 32'd0);
    chk("b_state_on_time", 32'(b_if.state), 32'd3);
    check_a("relock_hold", 3'b111, 1'b0, 2'd1);
    repeat (270) @(negedge clk);
    #1 check_a("pre_rst_n", 3'b110, 1'b0, 2'd2);
    rst_n = 1'b0;
    #1 check_a("async_rst", 3'b111, 1'b0, 2'd0);
    chk("async_rst_b_rst", 32'(b_if.rst_out), 32'd1);
    chk("async_rst_b_ready", 32'(b_if.ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 60; s++) begin
      locked = $urandom_range(0, 9) != 0;
      btn    = $urandom_range(0, 7) == 0;
      repeat ($urandom_range(1, 400)) @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    locked = 1'b1;
    btn    = 1'b0;
    repeat (400) @(negedge clk);
    #3 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
